// File: rtl/prod_accum_if.sv
// Handshake bundle between the product stream source / result consumer and prod_accum.
// master drives jobs and products and consumes results; slave is the accumulator.
interface prod_accum_if #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;
  logic             busy;

  modport master (
    output start, len, in_valid, prod, out_ready,
    input  in_ready, out_valid, acc_out, ovf, busy
  );

  modport slave (
    input  start, len, in_valid, prod, out_ready,
    output in_ready, out_valid, acc_out, ovf, busy
  );
endinterface

// File: rtl/prod_accum.sv
// Saturating accumulator for the 16-bit approximate-multiplier product stream.
// One job at a time: IDLE takes a length, ACC sums that many products, DONE holds the result.
module prod_accum #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  prod_accum_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic             ovf_q, ovf_nxt;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             hs;
  logic [ACC_W:0]   sum;

  // in_ready_q is only ever high in ACC, so a handshake implies state == ACC
  assign hs  = bus.in_valid & in_ready_q;
  assign sum = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, bus.prod};

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    remaining_nxt = remaining;
    ovf_nxt       = ovf_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt = '0;
          ovf_nxt = 1'b0;
          if (bus.len != '0) begin
            remaining_nxt = bus.len;
            state_nxt     = ACC;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ACC: begin
        if (hs) begin
          if (sum[ACC_W]) begin
            acc_nxt = '1;
            ovf_nxt = 1'b1;
          end else begin
            acc_nxt = sum[ACC_W-1:0];
          end
          remaining_nxt = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      remaining   <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      remaining   <= remaining_nxt;
      ovf_q       <= ovf_nxt;
      in_ready_q  <= (state_nxt == ACC);
      out_valid_q <= (state_nxt == DONE);
      busy_q      <= (state_nxt != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: a vector table on a 24-bit instance plus hand
// sequences for saturation (17-bit instance) and asynchronous reset mid-job.
module tb_prod_accum;

  logic clk;
  logic rst_n;

  prod_accum_if #(.ACC_W(24), .LEN_W(8)) bus24 ();
  prod_accum_if #(.ACC_W(17), .LEN_W(8)) bus17 ();

  prod_accum #(.ACC_W(24), .LEN_W(8)) dut24 (.clk(clk), .rst_n(rst_n), .bus(bus24));
  prod_accum #(.ACC_W(17), .LEN_W(8)) dut17 (.clk(clk), .rst_n(rst_n), .bus(bus17));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] prod;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic        exp_busy;
    logic [31:0] exp_acc;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];
  int   applied;
  int   miscompares;

  function automatic vec_t mk(logic s, logic [7:0] l, logic iv, logic [15:0] p, logic ordy,
                              logic eir, logic eov, logic eb, logic [31:0] ea, logic eo);
    vec_t v;
    v.start = s; v.len = l; v.in_valid = iv; v.prod = p; v.out_ready = ordy;
    v.exp_in_ready = eir; v.exp_out_valid = eov; v.exp_busy = eb;
    v.exp_acc = ea; v.exp_ovf = eo;
    return v;
  endfunction

  // Drive one cycle of inputs on the selected instance, idle the other, sample after the edge
  task automatic applyStimulus(input int sel, input logic s, input logic [7:0] l, input logic iv,
                               input logic [15:0] p, input logic ordy);
    bus24.start = 1'b0; bus24.len = '0; bus24.in_valid = 1'b0; bus24.prod = '0; bus24.out_ready = 1'b0;
    bus17.start = 1'b0; bus17.len = '0; bus17.in_valid = 1'b0; bus17.prod = '0; bus17.out_ready = 1'b0;
    if (sel == 0) begin
      bus24.start = s; bus24.len = l; bus24.in_valid = iv; bus24.prod = p; bus24.out_ready = ordy;
    end else begin
      bus17.start = s; bus17.len = l; bus17.in_valid = iv; bus17.prod = p; bus17.out_ready = ordy;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic eir, input logic eov,
                             input logic eb, input logic [31:0] ea, input logic eo);
    logic        ir, ov, bsy, of;
    logic [31:0] acc;
    if (sel == 0) begin
      ir = bus24.in_ready; ov = bus24.out_valid; bsy = bus24.busy; of = bus24.ovf;
      acc = 32'(bus24.acc_out);
    end else begin
      ir = bus17.in_ready; ov = bus17.out_valid; bsy = bus17.busy; of = bus17.ovf;
      acc = 32'(bus17.acc_out);
    end
    applied++;
    if (ir !== eir || ov !== eov || bsy !== eb || acc !== ea || of !== eo) begin
      miscompares++;
      $display("[TB] FAIL %s: got in_ready=%0b out_valid=%0b busy=%0b acc_out=%0d ovf=%0b, expected in_ready=%0b out_valid=%0b busy=%0b acc_out=%0d ovf=%0b",
               name, ir, ov, bsy, acc, of, eir, eov, eb, ea, eo);
    end
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus24.start = 1'b0; bus24.len = '0; bus24.in_valid = 1'b0; bus24.prod = '0; bus24.out_ready = 1'b0;
    bus17.start = 1'b0; bus17.len = '0; bus17.in_valid = 1'b0; bus17.prod = '0; bus17.out_ready = 1'b0;

    // basic len=4 job, extra in_valid in DONE must not be taken
    vecs.push_back(mk(1, 4, 0, 0,   0, 1, 0, 1, 0,    0));
    vecs.push_back(mk(0, 0, 1, 100, 0, 1, 0, 1, 100,  0));
    vecs.push_back(mk(0, 0, 1, 200, 0, 1, 0, 1, 300,  0));
    vecs.push_back(mk(0, 0, 1, 300, 0, 1, 0, 1, 600,  0));
    vecs.push_back(mk(0, 0, 1, 400, 0, 0, 1, 1, 1000, 0));
    vecs.push_back(mk(0, 0, 1, 999, 1, 0, 0, 0, 1000, 0));
    // zero-length job
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // gaps with garbage prod, then backpressure
    vecs.push_back(mk(1, 3, 0, 0,       0, 1, 0, 1, 0,  0));
    vecs.push_back(mk(0, 0, 1, 7,       0, 1, 0, 1, 7,  0));
    vecs.push_back(mk(0, 0, 0, 16'hffff, 0, 1, 0, 1, 7,  0));
    vecs.push_back(mk(0, 0, 0, 16'hffff, 0, 1, 0, 1, 7,  0));
    vecs.push_back(mk(0, 0, 1, 9,       0, 1, 0, 1, 16, 0));
    vecs.push_back(mk(0, 0, 0, 16'hffff, 0, 1, 0, 1, 16, 0));
    vecs.push_back(mk(0, 0, 1, 11,      0, 0, 1, 1, 27, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 27, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 27, 0));
    // start ignored in ACC and DONE
    vecs.push_back(mk(1, 2, 0, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 9, 1, 3, 0, 1, 0, 1, 3, 0));
    vecs.push_back(mk(1, 9, 1, 4, 0, 0, 1, 1, 7, 0));
    vecs.push_back(mk(1, 9, 0, 0, 0, 0, 1, 1, 7, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 7, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 0));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset24", 0, 0, 0, 0, 0, 0);
    checkOutput("reset17", 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].start, vecs[i].len, vecs[i].in_valid, vecs[i].prod, vecs[i].out_ready);
      checkOutput($sformatf("vec%0d", i), 0, vecs[i].exp_in_ready, vecs[i].exp_out_valid,
                  vecs[i].exp_busy, vecs[i].exp_acc, vecs[i].exp_ovf);
    end

    // saturation on the 17-bit instance, then ovf cleared by the next job
    applyStimulus(1, 1, 3, 0, 0, 0);
    checkOutput("sat_start", 1, 1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 16'hffff, 0);
    checkOutput("sat_p1", 1, 1, 0, 1, 65535, 0);
    applyStimulus(1, 0, 0, 1, 16'hffff, 0);
    checkOutput("sat_p2", 1, 1, 0, 1, 131070, 0);
    applyStimulus(1, 0, 0, 1, 16'hffff, 0);
    checkOutput("sat_p3", 1, 0, 1, 1, 131071, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("sat_idle", 1, 0, 0, 0, 131071, 1);
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkOutput("sat_restart", 1, 1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 5, 0);
    checkOutput("sat_next", 1, 0, 1, 1, 5, 0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("sat_next_idle", 1, 0, 0, 0, 5, 0);

    // asynchronous reset part-way through a len=5 job
    applyStimulus(0, 1, 5, 0, 0, 0);
    checkOutput("rst_start", 0, 1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 10, 0);
    applyStimulus(0, 0, 0, 1, 20, 0);
    checkOutput("rst_partial", 0, 1, 0, 1, 30, 0);
    bus24.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("rst_held", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("rst_after_start", 0, 1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 42, 0);
    checkOutput("rst_after_done", 0, 0, 1, 1, 42, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("rst_after_idle", 0, 0, 0, 0, 42, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
